// File: rtl/rtc_pkg.sv
// Shared constants for the DS1302 sequencer: command bytes, field indices,
// FSM encoding and BCD range limits.
package rtc_pkg;

    localparam logic [7:0] WP_ADDR       = 8'h8E;
    localparam logic [7:0] WP_ON         = 8'h80;
    localparam logic [7:0] WP_OFF        = 8'h00;
    localparam logic [7:0] FIELD_WR_BASE = 8'h80;
    localparam logic [7:0] FIELD_RD_BASE = 8'h81;

    typedef enum logic [2:0] {SEC, MIN, HOUR, DATE, MONTH, DAY, YEAR} field_e;

    typedef enum logic [2:0] {
        S_UNPROT,
        S_WR,
        S_PROT,
        S_WAIT,
        S_RD,
        S_COMMIT
    } state_e;

    // Index 7 is a pad entry so any 3-bit field index stays in range.
    localparam logic [7:0][7:0] BCD_MIN = {8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00};
    localparam logic [7:0][7:0] BCD_MAX = {8'h99, 8'h99, 8'h07, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59};

    function automatic logic bcd_ok(input logic [2:0] k, input logic [7:0] b);
        return (b[3:0] <= 4'd9) && (b[7:4] <= 4'd9) &&
               (b >= BCD_MIN[k]) && (b <= BCD_MAX[k]);
    endfunction

    function automatic logic [7:0] field_cmd(input logic [7:0] base, input logic [2:0] k);
        return base + {4'b0000, k, 1'b0};
    endfunction

endpackage

// File: rtl/ds1302_xfer.sv
// DS1302 3-wire engine: one command byte plus one data byte, LSB first,
// followed by a CE-low guard time before Done.
module ds1302_xfer #(
    parameter int SCLK_DIV = 25
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       Start,
    input  logic       Rw,
    input  logic [7:0] Cmd,
    input  logic [7:0] Wdata,
    output logic [7:0] Rdata,
    output logic       Done,
    output logic       RST,
    output logic       SCLK,
    inout  wire        SIO
);

    localparam int CW = $clog2(4 * SCLK_DIV);
    localparam logic [CW-1:0] HALF_LD = CW'(SCLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'(4 * SCLK_DIV - 1);

    typedef enum logic [1:0] {X_IDLE, X_LOW, X_HIGH, X_GAP} phase_e;

    phase_e        phase;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_idx;
    logic [15:0]   shreg;
    logic          rw;
    logic          sio_oe;
    logic          sio_out;

    assign SIO = sio_oe ? sio_out : 1'bz;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            phase   <= X_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            rw      <= 1'b0;
            sio_oe  <= 1'b0;
            sio_out <= 1'b0;
            RST     <= 1'b0;
            SCLK    <= 1'b0;
            Rdata   <= '0;
            Done    <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (phase)
                X_IDLE: if (Start) begin
                    rw      <= Rw;
                    shreg   <= {Wdata, Cmd};
                    sio_oe  <= 1'b1;
                    sio_out <= Cmd[0];
                    RST     <= 1'b1;
                    bit_idx <= '0;
                    cnt     <= HALF_LD;
                    phase   <= X_LOW;
                end
                X_LOW: if (cnt == '0) begin
                    // Last CLK before the rising edge: sample read data here.
                    if (rw && bit_idx[3]) Rdata <= {SIO, Rdata[7:1]};
                    SCLK  <= 1'b1;
                    cnt   <= HALF_LD;
                    phase <= X_HIGH;
                end else begin
                    cnt <= cnt - CW'(1);
                end
                X_HIGH: if (cnt == '0) begin
                    SCLK <= 1'b0;
                    if (bit_idx == 4'd15) begin
                        RST    <= 1'b0;
                        sio_oe <= 1'b0;
                        cnt    <= GAP_LD;
                        phase  <= X_GAP;
                    end else begin
                        bit_idx <= bit_idx + 4'd1;
                        shreg   <= {1'b0, shreg[15:1]};
                        sio_out <= shreg[1];
                        if (rw && bit_idx == 4'd7) sio_oe <= 1'b0;
                        cnt     <= HALF_LD;
                        phase   <= X_LOW;
                    end
                end else begin
                    cnt <= cnt - CW'(1);
                end
                X_GAP: if (cnt == '0) begin
                    Done  <= 1'b1;
                    phase <= X_IDLE;
                end else begin
                    cnt <= cnt - CW'(1);
                end
                default: phase <= X_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/rtc_ds1302_seq.sv
// DS1302 init / set / poll sequencer with coherent snapshot output.
// Optional build macro RTC_BCD_CHECK_EN enables BCD/range checking of reads.
//
// state    | meaning
// S_UNPROT | write WP register = 00
// S_WR     | write fields NUM_FIELDS-1 down to 0 (seconds last)
// S_PROT   | write WP register = 80, then Set_Ack if from Set_Req
// S_WAIT   | idle; Set_Req has priority over the poll timer
// S_RD     | read fields 0..NUM_FIELDS-1 into shadow
// S_COMMIT | shadow -> Time_Out, Time_Valid pulse (or Err on bad read)
module rtc_ds1302_seq #(
    parameter int          NUM_FIELDS    = 3,
    parameter int          POLL_DIV      = 50_000_000,
    parameter int          SCLK_DIV      = 25,
    parameter bit          INIT_ON_RESET = 1'b1,
    parameter logic [55:0] INIT_TIME     = 56'h00_00_00_00_00_49_00
) (
    input  logic                    CLK,
    input  logic                    RSTn,
    input  logic                    Set_Req,
    input  logic [8*NUM_FIELDS-1:0] Set_Time,
    output logic                    Set_Ack,
    output logic [8*NUM_FIELDS-1:0] Time_Out,
    output logic                    Time_Valid,
    output logic                    Busy,
    output logic                    Err,
    output logic                    RST,
    output logic                    SCLK,
    inout  wire                     SIO
);

    import rtc_pkg::*;

    localparam logic [2:0]  LAST    = 3'(NUM_FIELDS - 1);
    localparam logic [31:0] POLL_LD = (POLL_DIV == 0) ? 32'd0 : 32'(POLL_DIV - 1);

    state_e                         state;
    logic [NUM_FIELDS-1:0][7:0]     wr_time;
    logic [NUM_FIELDS-1:0][7:0]     shadow;
    logic [2:0]                     fld;
    logic                           from_set;
    logic                           xact;
    logic                           bad;
    logic [31:0]                    poll_cnt;
    logic                           x_start;
    logic                           x_rw;
    logic                           x_done;
    logic [7:0]                     x_cmd;
    logic [7:0]                     x_wdata;
    logic [7:0]                     x_rdata;
    logic [7:0]                     wr_byte;
    logic [7:0]                     rd_byte;
    logic                           rd_bad;

    // Clock-halt bit on seconds and 12/24 bit on hours are always written as 0.
    always_comb begin
        wr_byte = wr_time[fld];
        if (fld == SEC || fld == HOUR) wr_byte[7] = 1'b0;
        rd_byte = x_rdata;
        if (fld == SEC) rd_byte[7] = 1'b0;
    end

`ifdef RTC_BCD_CHECK_EN
    assign rd_bad = ~bcd_ok(fld, rd_byte);
`else
    assign rd_bad = 1'b0;
`endif

    ds1302_xfer #(.SCLK_DIV(SCLK_DIV)) u_xfer (
        .CLK   (CLK),
        .RSTn  (RSTn),
        .Start (x_start),
        .Rw    (x_rw),
        .Cmd   (x_cmd),
        .Wdata (x_wdata),
        .Rdata (x_rdata),
        .Done  (x_done),
        .RST   (RST),
        .SCLK  (SCLK),
        .SIO   (SIO)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state      <= S_UNPROT;
            wr_time    <= INIT_TIME[8*NUM_FIELDS-1:0];
            shadow     <= '0;
            fld        <= '0;
            from_set   <= 1'b0;
            xact       <= 1'b0;
            bad        <= 1'b0;
            poll_cnt   <= '0;
            x_start    <= 1'b0;
            x_rw       <= 1'b0;
            x_cmd      <= '0;
            x_wdata    <= '0;
            Set_Ack    <= 1'b0;
            Time_Out   <= '0;
            Time_Valid <= 1'b0;
            Busy       <= 1'b0;
            Err        <= 1'b0;
        end else begin
            x_start    <= 1'b0;
            Time_Valid <= 1'b0;
            Set_Ack    <= 1'b0;
            Busy       <= (state != S_WAIT);
            if (poll_cnt != '0) poll_cnt <= poll_cnt - 32'd1;

            case (state)
                S_UNPROT: if (!xact) begin
                    x_start <= 1'b1;
                    xact    <= 1'b1;
                    x_rw    <= 1'b0;
                    x_cmd   <= WP_ADDR;
                    x_wdata <= WP_OFF;
                end else if (x_done) begin
                    xact  <= 1'b0;
                    fld   <= LAST;
                    state <= (from_set || INIT_ON_RESET) ? S_WR : S_WAIT;
                end
                S_WR: if (!xact) begin
                    x_start <= 1'b1;
                    xact    <= 1'b1;
                    x_rw    <= 1'b0;
                    x_cmd   <= field_cmd(FIELD_WR_BASE, fld);
                    x_wdata <= wr_byte;
                end else if (x_done) begin
                    xact <= 1'b0;
                    if (fld == 3'd0) state <= S_PROT;
                    else             fld   <= fld - 3'd1;
                end
                S_PROT: if (!xact) begin
                    x_start <= 1'b1;
                    xact    <= 1'b1;
                    x_rw    <= 1'b0;
                    x_cmd   <= WP_ADDR;
                    x_wdata <= WP_ON;
                end else if (x_done) begin
                    xact     <= 1'b0;
                    Set_Ack  <= from_set;
                    from_set <= 1'b0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    // Set_Req is still high in the Set_Ack cycle; do not re-accept it.
                    if (Set_Req && !Set_Ack) begin
                        from_set <= 1'b1;
                        wr_time  <= Set_Time;
                        Err      <= 1'b0;
                        state    <= S_UNPROT;
                    end else if (poll_cnt == '0) begin
                        poll_cnt <= POLL_LD;
                        fld      <= '0;
                        bad      <= 1'b0;
                        state    <= S_RD;
                    end
                end
                S_RD: if (!xact) begin
                    x_start <= 1'b1;
                    xact    <= 1'b1;
                    x_rw    <= 1'b1;
                    x_cmd   <= field_cmd(FIELD_RD_BASE, fld);
                    x_wdata <= '0;
                end else if (x_done) begin
                    xact        <= 1'b0;
                    shadow[fld] <= rd_byte;
                    bad         <= bad | rd_bad;
                    if (fld == LAST) state <= S_COMMIT;
                    else             fld   <= fld + 3'd1;
                end
                S_COMMIT: begin
                    if (!bad) begin
                        Time_Out   <= shadow;
                        Time_Valid <= 1'b1;
                    end else begin
                        Err <= 1'b1;
                    end
                    state <= S_WAIT;
                end
                default: state <= S_UNPROT;
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_ds1302_seq.sv
// Directed bench for rtc_ds1302_seq with a behavioural DS1302 pin model.
module tb_rtc_ds1302_seq;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        Set_Req = 1'b0;
    logic [23:0] Set_Time = '0;
    logic        Set_Ack, Time_Valid, Busy, Err, RST, SCLK;
    logic [23:0] Time_Out;
    tri          SIO;

    int n_assert = 0;
    int n_fail   = 0;
    int tv_cnt   = 0;
    int ack_cnt  = 0;
    int viol     = 0;
    int err_seen = 0;
    logic [23:0] prev_to = '0;

    always #5 CLK = ~CLK;

    rtc_ds1302_seq #(
        .NUM_FIELDS    (3),
        .POLL_DIV      (0),
        .SCLK_DIV      (2),
        .INIT_ON_RESET (1'b1),
        .INIT_TIME     (56'h00_00_00_00_00_49_00)
    ) u_dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .Set_Req    (Set_Req),
        .Set_Time   (Set_Time),
        .Set_Ack    (Set_Ack),
        .Time_Out   (Time_Out),
        .Time_Valid (Time_Valid),
        .Busy       (Busy),
        .Err        (Err),
        .RST        (RST),
        .SCLK       (SCLK),
        .SIO        (SIO)
    );

    // DS1302 model: registers 0..6 are time fields, 7 is write-protect.
    logic [7:0]  mreg [0:7];
    logic [7:0]  mcmd = '0;
    logic [7:0]  mdat = '0;
    int          mbit = 0;
    logic        m_oe = 1'b0;
    logic        m_out = 1'b0;
    logic [15:0] logq [$];

    assign SIO = m_oe ? m_out : 1'bz;

    initial begin
        for (int i = 0; i < 7; i++) mreg[i] = 8'h00;
        mreg[7] = 8'h80;
    end

    always @(posedge SCLK or negedge SCLK or negedge RST) begin
        if (!RST) begin
            mbit = 0;
            m_oe = 1'b0;
        end else if (SCLK) begin
            if (mbit < 8) mcmd[mbit] = SIO;
            else if (mbit < 16 && !mcmd[0]) mdat[mbit-8] = SIO;
            mbit++;
            if (mbit == 16 && !mcmd[0]) begin
                logq.push_back({mcmd, mdat});
                if (mcmd[3:1] == 3'd7 || !mreg[7][7]) mreg[mcmd[3:1]] = mdat;
            end
        end else if (mbit >= 8 && mbit < 16 && mcmd[0]) begin
            m_oe  = 1'b1;
            m_out = mreg[mcmd[3:1]][mbit-8];
        end
    end

    always @(negedge CLK) begin
        if (RSTn && !Time_Valid && Time_Out !== prev_to) viol++;
        prev_to = Time_Out;
        if (Time_Valid) tv_cnt++;
        if (Set_Ack) ack_cnt++;
        if (Err) err_seen++;
    end

    logic [15:0] init_seq [5] = '{16'h8E00, 16'h8400, 16'h8249, 16'h8000, 16'h8E80};
    logic [15:0] set_seq  [5] = '{16'h8E00, 16'h8412, 16'h8234, 16'h8056, 16'h8E80};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_tv(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            if (Time_Valid) begin ok = 1'b1; break; end
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_ack(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            if (Set_Ack) begin ok = 1'b1; break; end
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        int l0;
        int tv0;
        bit ok;

        repeat (3) @(negedge CLK);
        chk("rst_time_out", 32'(Time_Out), 32'h0);
        chk("rst_valid", 32'(Time_Valid), 32'd0);
        chk("rst_ack", 32'(Set_Ack), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_err", 32'(Err), 32'd0);
        chk("rst_ce", 32'(RST), 32'd0);
        chk("rst_sclk", 32'(SCLK), 32'd0);
        RSTn = 1'b1;

        wait_tv("init_tv");
        chk("init_log_len", 32'(logq.size()), 32'd5);
        for (int i = 0; i < 5; i++) chk($sformatf("init_log%0d", i), 32'(logq[i]), 32'(init_seq[i]));
        chk("init_time", 32'(Time_Out), 32'h004900);

        // Model holds 23:59:59 with CH set; read masking must clear it.
        mreg[2] = 8'h23; mreg[1] = 8'h59; mreg[0] = 8'hD9;
        wait_tv("roll_tv1");
        chk("roll_235959", 32'(Time_Out), 32'h235959);
        mreg[2] = 8'h00; mreg[1] = 8'h00; mreg[0] = 8'h00;
        wait_tv("roll_tv2");
        chk("roll_000000", 32'(Time_Out), 32'h000000);

        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            if (RST && mbit >= 8 && mcmd == 8'h83) begin ok = 1'b1; break; end
        end
        chk("mid_rd_seen", 32'(ok), 32'd1);
        chk("busy_in_rd", 32'(Busy), 32'd1);
        mreg[2] = 8'h05;
        Set_Time = 24'h123456;
        Set_Req  = 1'b1;
        l0 = logq.size();
        wait_tv("mid_tv");
        chk("mid_commit_first", 32'(Time_Out), 32'h050000);
        chk("mid_no_write_yet", 32'(logq.size()), 32'(l0));
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            if (logq.size() > l0) begin ok = 1'b1; break; end
        end
        chk("set_started", 32'(ok), 32'd1);
        Set_Time = 24'h999999;
        wait_ack("set_ack");
        Set_Req = 1'b0;
        for (int i = 0; i < 5; i++) chk($sformatf("set_log%0d", i), 32'(logq[l0+i]), 32'(set_seq[i]));
        wait_tv("set_tv");
        chk("set_time", 32'(Time_Out), 32'h123456);
        chk("ack_pulses", 32'(ack_cnt), 32'd1);

        l0 = logq.size();
        Set_Time = 24'h9234D6;
        Set_Req  = 1'b1;
        wait_ack("mask_ack");
        Set_Req = 1'b0;
        chk("mask_hour", 32'(logq[l0+1]), 32'h8412);
        chk("mask_sec", 32'(logq[l0+3]), 32'h8056);
        wait_tv("mask_tv");
        chk("mask_time", 32'(Time_Out), 32'h123456);

`ifdef RTC_BCD_CHECK_EN
        tv0 = tv_cnt;
        mreg[1] = 8'h6A;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            if (Err) begin ok = 1'b1; break; end
        end
        chk("bcd_err", 32'(ok), 32'd1);
        chk("bcd_no_tv", 32'(tv_cnt), 32'(tv0));
        chk("bcd_hold", 32'(Time_Out), 32'h123456);
        mreg[1] = 8'h34;
        Set_Time = 24'h123456;
        Set_Req  = 1'b1;
        wait_ack("bcd_ack");
        Set_Req = 1'b0;
        chk("bcd_err_clr", 32'(Err), 32'd0);
`else
        tv0 = tv_cnt;
        mreg[1] = 8'h6A;
        wait_tv("nochk_tv");
        chk("nochk_time", 32'(Time_Out), 32'h126A56);
        chk("nochk_err", 32'(Err), 32'd0);
        mreg[1] = 8'h34;
        wait_tv("nochk_tv2");
        chk("nochk_time2", 32'(Time_Out), 32'h123456);
`endif

        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            if (RST && mcmd[0] && mbit == 10) begin ok = 1'b1; break; end
        end
        chk("abort_point_seen", 32'(ok), 32'd1);
        RSTn = 1'b0;
        #1;
        chk("abort_ce", 32'(RST), 32'd0);
        chk("abort_sclk", 32'(SCLK), 32'd0);
        chk("abort_sio_oe", 32'(u_dut.u_xfer.sio_oe), 32'd0);
        chk("abort_busy", 32'(Busy), 32'd0);
        chk("abort_time", 32'(Time_Out), 32'h0);
        logq.delete();
        repeat (3) @(negedge CLK);
        RSTn = 1'b1;
        wait_tv("reinit_tv");
        chk("reinit_log_len", 32'(logq.size()), 32'd5);
        for (int i = 0; i < 5; i++) chk($sformatf("reinit_log%0d", i), 32'(logq[i]), 32'(init_seq[i]));
        chk("reinit_time", 32'(Time_Out), 32'h004900);

        chk("time_out_only_on_valid", 32'(viol), 32'd0);
`ifndef RTC_BCD_CHECK_EN
        chk("err_never_set", 32'(err_seen), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
